mac_seq: RTL and testbench
==========================

# mac_seq

Dot-product sequencer for the team's `mac` multiply-accumulate datapath. On a start command it clears the MAC and streams exactly `len` operand pairs into it through a valid/ready handshake. After the final product has been absorbed, it captures the accumulator and presents it on a valid/ready result port. The block sits between an operand source (DMA or FIFO) and one external `mac` instance, whose `clear`/`en`/`a`/`b` it drives and whose `acc` it reads.

## Interface
- `DW`, 16, operand width; must equal the attached MAC's `DW`.
- `ACCW`, 40, accumulator width; must equal the attached MAC's `ACCW`.
- `LW`, 8, width of the vector-length field.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a vector; sampled only in IDLE.
- `len`  in  LW  number of operand pairs; latched when `start` is accepted.
- `abort`  in  1  synchronous abandon of the current vector from any state.
- `busy`  out  1  high whenever state != IDLE.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  operand pair accepted this cycle.
- `in_a`, `in_b`  in  DW  operands.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumer ready.
- `out_data`  out  ACCW  registered dot-product result.
- `mac_clear`  out  1  drives the MAC's `clear`.
- `mac_en`  out  1  drives the MAC's `en`.
- `mac_a`, `mac_b`  out  DW  drive the MAC's `a`/`b`; combinational copies of `in_a`/`in_b`.
- `mac_acc`  in  ACCW  the MAC's `acc`.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 → CLEAR; latch `len` into `len_q`; zero the beat counter `cnt` (LW bits).
- CLEAR:
  - `mac_clear`=1 for exactly this cycle.
  - Next state is RUN if `len_q` != 0, else DRAIN.
- RUN:
  - `in_ready`=1.
  - Beat = `in_valid` && `in_ready`; `mac_en` = beat.
  - Each beat increments `cnt`.
  - A beat with `cnt` == `len_q`-1 → DRAIN.
  - Bubbles (`in_valid`=0) stall with no MAC update.
- DRAIN:
  - One cycle for the MAC register to settle.
  - `out_data` <= `mac_acc` at the end of this cycle; → DONE.
- DONE:
  - `out_valid`=1; `out_data` is held stable.
  - `out_valid` && `out_ready` → IDLE.
- Outside RUN: `in_ready`=0 and `mac_en`=0.
- Outside CLEAR: `mac_clear`=0.
- `start` outside IDLE is ignored; it is not queued.
- `abort`=1 in any state → IDLE next cycle, highest priority.
  - `abort` overrides `start`, beats and the result handshake in that cycle.
  - In RUN, `mac_en` is forced to 0 while `abort` is high, so the aborted beat is not accepted.
  - `out_valid` drops with no handshake.
  - The MAC is not cleared on abort; the next CLEAR handles it.
- Arithmetic:
  - The result is whatever the MAC holds: the sum of `len` unsigned products, modulo 2^ACCW.
  - The sequencer does no arithmetic and performs no overflow detection.
- `len`=0 yields `out_data`=0 via the CLEAR → DRAIN path.
- `len` = 2^LW-1 is the maximum vector length.

## Timing
- Reset (`nreset` low, asynchronous) values:
  - state=IDLE, `cnt`=0, `len_q`=0, `out_data`=0.
  - `busy`=0, `in_ready`=0, `out_valid`=0, `mac_clear`=0, `mac_en`=0.
- Reset mid-vector abandons it immediately. The MAC is independent and is cleared by the next CLEAR.
- Latency is counted with `start` sampled at edge E0:
  - CLEAR occupies cycle 1.
  - RUN begins in cycle 2.
  - With no bubbles, the last beat is in cycle `len`+1 and DRAIN is in cycle `len`+2.
  - `out_valid` rises in cycle `len`+3.
- Throughput: 1 beat per cycle in RUN.
- Per-vector overhead: 3 cycles plus the result handshake.
  - Earliest next `start` acceptance is the cycle after the handshake, when the state is back in IDLE.
- `out_valid`, `out_data` and `busy` are registered or decoded from state; no combinational path from `out_ready` to `out_valid`.
- `in_ready` is a decode of state only; it does not depend on `in_valid`.

## Test plan
- Basic: `len`=4, pairs (1,2),(3,4),(5,6),(7,8), no bubbles, `out_ready`=1 → `mac_clear` pulse in cycle 1, 4 `mac_en` pulses, `out_data`=100, `out_valid` in cycle 7 for one cycle.
- Bubbles/backpressure: `len`=3, pairs (10,10),(20,20),(30,30) with `in_valid` toggling 1,0,1,0,1; `out_ready` low 5 cycles → `out_data`=1400 held stable with `out_valid` high through the stall, IDLE after the handshake.
- Zero length: `len`=0, `start` pulse → no `in_ready`, `out_data`=0, `out_valid` in cycle 3.
- Wrap: DW=16, ACCW=40, `len`=255, every pair (0xFFFF,0xFFFF) → `out_data` = 255×0xFFFE0001 mod 2^40; next vector `len`=1 (2,3) → 6, confirming the clear.
- Abort: `len`=5, abort after 2 beats, then new `start` `len`=2 (4,5),(6,7) → no result for the first vector, `out_data`=62; `start` asserted during RUN is ignored.
- Async reset: assert `nreset` low mid-RUN and in DONE → all outputs at reset values immediately; a subsequent vector `len`=1 (9,9) → 81.

Source files
------------

// File: rtl/mac_seq_if.sv
// Bundle of the sequencer's control, operand, result and MAC-side signals.
// The sequencer uses the slave view; the surrounding system uses the master view.
interface mac_seq_if #(
  parameter int DW   = 16,
  parameter int ACCW = 40,
  parameter int LW   = 8
);
  logic            start;
  logic [LW-1:0]   len;
  logic            abort;
  logic            busy;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_data;
  logic            mac_clear;
  logic            mac_en;
  logic [DW-1:0]   mac_a;
  logic [DW-1:0]   mac_b;
  logic [ACCW-1:0] mac_acc;

  modport slave (
    input  start, len, abort, in_valid, in_a, in_b, out_ready, mac_acc,
    output busy, in_ready, out_valid, out_data, mac_clear, mac_en, mac_a, mac_b
  );

  modport master (
    output start, len, abort, in_valid, in_a, in_b, out_ready, mac_acc,
    input  busy, in_ready, out_valid, out_data, mac_clear, mac_en, mac_a, mac_b
  );
endinterface

// File: rtl/mac_seq.sv
// Dot-product sequencer: clears an external MAC, streams len operand pairs into it
// and returns the captured accumulator on a valid/ready result port.
module mac_seq #(
  parameter int DW   = 16,
  parameter int ACCW = 40,
  parameter int LW   = 8
) (
  input  logic     clk,
  input  logic     nreset,
  mac_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [LW-1:0]   r_len_q;
  logic [LW-1:0]   r_cnt;
  logic [ACCW-1:0] r_out_data;

  logic            w_in_ready;
  logic            w_beat;
  logic            w_last;
  logic            w_busy;
  logic            w_out_valid;
  logic            w_mac_clear;
  logic [DW-1:0]   w_mac_a;
  logic [DW-1:0]   w_mac_b;

  // A beat needs the operand, the RUN state and no abort in the same cycle.
  assign w_beat = bus.in_valid && w_in_ready && !bus.abort;
  assign w_last = (r_cnt == (r_len_q - LW'(1)));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (bus.abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (bus.start) w_next = S_CLEAR;
        S_CLEAR: w_next = (r_len_q != '0) ? S_RUN : S_DRAIN;
        S_RUN:   if (w_beat && w_last) w_next = S_DRAIN;
        S_DRAIN: w_next = S_DONE;
        S_DONE:  if (bus.out_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy      = (r_state != S_IDLE);
    w_in_ready  = (r_state == S_RUN);
    w_out_valid = (r_state == S_DONE);
    w_mac_clear = (r_state == S_CLEAR);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_len_q <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE && bus.start && !bus.abort) begin
      r_len_q <= bus.len;
      r_cnt   <= '0;
    end else if (w_beat) begin
      r_cnt <= r_cnt + LW'(1);
    end
  end

  // The MAC register has settled by DRAIN, so its value is final here.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_out_data <= '0;
    end else if (r_state == S_DRAIN && !bus.abort) begin
      r_out_data <= bus.mac_acc;
    end
  end

  assign w_mac_a = bus.in_a;
  assign w_mac_b = bus.in_b;

  assign bus.busy      = w_busy;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.mac_clear = w_mac_clear;
  assign bus.mac_en    = w_beat;
  assign bus.mac_a     = w_mac_a;
  assign bus.mac_b     = w_mac_b;

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq with a behavioural MAC attached to its MAC-side port.
module tb_mac_seq;

  logic clk;
  logic nreset;

  mac_seq_if #(.DW(16), .ACCW(40), .LW(8)) bus ();

  mac_seq #(.DW(16), .ACCW(40), .LW(8)) u_dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External MAC: unsigned products accumulated modulo 2^40.
  logic [39:0] acc;
  always @(posedge clk) begin
    if (bus.mac_clear) acc <= '0;
    else if (bus.mac_en) acc <= acc + (40'(bus.mac_a) * 40'(bus.mac_b));
  end
  assign bus.mac_acc = acc;

  int nchk = 0;
  int nerr = 0;

  logic [15:0] va [256];
  logic [15:0] vb [256];

  typedef struct {
    int                n;
    logic [3:0][15:0]  a;
    logic [3:0][15:0]  b;
    logic [39:0]       exp;
    int                vcyc;
  } vec_t;

  vec_t tbl [5];

  logic [39:0] res;
  int vc, nc, ne, nr, vl;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [63:0] a, input logic [63:0] b,
                              input logic [39:0] e, input int c);
    vec_t v;
    v.n = n; v.a = a; v.b = b; v.exp = e; v.vcyc = c;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops(input int c, input int idx, input int n, input bit bub);
    bus.in_valid = (idx < n) && (!bub || ((c % 2) == 0));
    bus.in_a     = va[(idx < 256) ? idx : 0];
    bus.in_b     = vb[(idx < 256) ? idx : 0];
  endtask

  // Runs one vector from the start pulse through the result handshake; cycle 0 is the start cycle.
  task automatic run_vector(input int n, input bit bub, input int stall,
                            output logic [39:0] r, output int vcyc, output int nclr,
                            output int nen, output int nrdy, output int vlen);
    int  idx;
    int  c;
    int  dcnt;
    bit  done;
    idx = 0; c = 0; dcnt = 0; done = 0;
    r = '0; vcyc = -1; nclr = 0; nen = 0; nrdy = 0; vlen = 0;
    bus.start     = 1'b1;
    bus.len       = 8'(n);
    bus.out_ready = (stall == 0);
    drive_ops(c, idx, n, bub);
    while (!done && c < 2000) begin
      @(negedge clk);
      if (bus.mac_clear) nclr++;
      if (bus.mac_en) begin nen++; idx++; end
      if (bus.in_ready) nrdy++;
      if (bus.out_valid) begin
        if (vcyc < 0) begin
          vcyc = c;
          r    = bus.out_data;
        end else begin
          chk("out_data_hold", 64'(bus.out_data), 64'(r));
        end
        vlen++;
        if (bus.out_ready) done = 1;
        else dcnt++;
      end
      tick();
      c++;
      bus.start     = 1'b0;
      bus.out_ready = (dcnt >= stall);
      drive_ops(c, idx, n, bub);
    end
    if (!done) chk("vector_timeout", 64'd0, 64'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    nreset = 1'b0;
    bus.start = 1'b0; bus.len = '0; bus.abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin va[i] = '0; vb[i] = '0; end

    tbl[0] = mk(4, {16'd7, 16'd5, 16'd3, 16'd1}, {16'd8, 16'd6, 16'd4, 16'd2}, 40'd100, 7);
    tbl[1] = mk(0, 64'd0, 64'd0, 40'd0, 3);
    tbl[2] = mk(1, {48'd0, 16'd9}, {48'd0, 16'd9}, 40'd81, 4);
    tbl[3] = mk(2, {32'd0, 16'd6, 16'd4}, {32'd0, 16'd7, 16'd5}, 40'd62, 5);
    tbl[4] = mk(3, {16'd0, 16'd3, 16'd2, 16'd1}, {16'd0, 16'd3, 16'd2, 16'd1}, 40'd14, 6);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mac_clear", 64'(bus.mac_clear), 64'd0);
    chk("rst_mac_en", 64'(bus.mac_en), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    nreset = 1'b1;
    tick();

    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 4; k++) begin va[k] = tbl[t].a[k]; vb[k] = tbl[t].b[k]; end
      run_vector(tbl[t].n, 1'b0, 0, res, vc, nc, ne, nr, vl);
      chk($sformatf("tbl%0d_data", t), 64'(res), 64'(tbl[t].exp));
      chk($sformatf("tbl%0d_vcyc", t), 64'(vc), 64'(tbl[t].vcyc));
      chk($sformatf("tbl%0d_clear", t), 64'(nc), 64'd1);
      chk($sformatf("tbl%0d_en", t), 64'(ne), 64'(tbl[t].n));
      chk($sformatf("tbl%0d_ready", t), 64'(nr), 64'(tbl[t].n));
      chk($sformatf("tbl%0d_vlen", t), 64'(vl), 64'd1);
      @(negedge clk);
      chk($sformatf("tbl%0d_idle", t), 64'(bus.busy), 64'd0);
      tick();
    end

    // Bubbles on the operand stream and a stalled result consumer.
    va[0] = 16'd10; vb[0] = 16'd10; va[1] = 16'd20; vb[1] = 16'd20; va[2] = 16'd30; vb[2] = 16'd30;
    run_vector(3, 1'b1, 5, res, vc, nc, ne, nr, vl);
    chk("bub_data", 64'(res), 64'd1400);
    chk("bub_vcyc", 64'(vc), 64'd8);
    chk("bub_en", 64'(ne), 64'd3);
    chk("bub_vlen", 64'(vl), 64'd6);
    @(negedge clk);
    chk("bub_idle", 64'(bus.busy), 64'd0);
    tick();

    // Maximum length with full-scale operands, then a short vector to confirm the clear.
    for (int k = 0; k < 256; k++) begin va[k] = 16'hFFFF; vb[k] = 16'hFFFF; end
    run_vector(255, 1'b0, 0, res, vc, nc, ne, nr, vl);
    chk("wrap_data", 64'(res), 64'(40'(40'd255 * 40'hFFFE0001)));
    chk("wrap_vcyc", 64'(vc), 64'd258);
    chk("wrap_en", 64'(ne), 64'd255);
    tick();
    va[0] = 16'd2; vb[0] = 16'd3;
    run_vector(1, 1'b0, 0, res, vc, nc, ne, nr, vl);
    chk("after_wrap_data", 64'(res), 64'd6);
    tick();

    // Abort after two beats; a start during RUN must be ignored.
    bus.start = 1'b1; bus.len = 8'd5;
    bus.in_valid = 1'b1; bus.in_a = 16'd1; bus.in_b = 16'd1;
    tick();
    bus.start = 1'b0;
    tick();
    @(negedge clk);
    chk("abort_beat0", 64'(bus.mac_en), 64'd1);
    tick();
    bus.start = 1'b1; bus.len = 8'd0;
    @(negedge clk);
    chk("abort_beat1", 64'(bus.mac_en), 64'd1);
    tick();
    @(negedge clk);
    chk("start_in_run_ignored", 64'(bus.in_ready), 64'd1);
    bus.abort = 1'b1;
    #1;
    chk("abort_blocks_beat", 64'(bus.mac_en), 64'd0);
    tick();
    bus.abort = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_idle", 64'(bus.busy), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("abort_no_result", 64'(bus.out_valid), 64'd0);
    end
    tick();
    va[0] = 16'd4; vb[0] = 16'd5; va[1] = 16'd6; vb[1] = 16'd7;
    run_vector(2, 1'b0, 0, res, vc, nc, ne, nr, vl);
    chk("post_abort_data", 64'(res), 64'd62);
    chk("post_abort_vcyc", 64'(vc), 64'd5);
    tick();

    // Asynchronous reset in RUN.
    bus.start = 1'b1; bus.len = 8'd3; bus.in_valid = 1'b1; bus.in_a = 16'd1; bus.in_b = 16'd1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2 nreset = 1'b0;
    #1;
    chk("arst_run_busy", 64'(bus.busy), 64'd0);
    chk("arst_run_in_ready", 64'(bus.in_ready), 64'd0);
    chk("arst_run_mac_en", 64'(bus.mac_en), 64'd0);
    chk("arst_run_mac_clear", 64'(bus.mac_clear), 64'd0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 nreset = 1'b1;
    tick();

    // Asynchronous reset while the result waits in DONE.
    bus.start = 1'b1; bus.len = 8'd1; bus.in_valid = 1'b1; bus.in_a = 16'd7; bus.in_b = 16'd7;
    bus.out_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    begin
      int w;
      w = 0;
      while (!bus.out_valid && w < 20) begin tick(); w++; end
      chk("arst_done_reached", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    #2 nreset = 1'b0;
    #1;
    chk("arst_done_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_done_out_data", 64'(bus.out_data), 64'd0);
    chk("arst_done_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #2 nreset = 1'b1;
    tick();
    va[0] = 16'd9; vb[0] = 16'd9;
    run_vector(1, 1'b0, 0, res, vc, nc, ne, nr, vl);
    chk("post_arst_data", 64'(res), 64'd81);
    chk("post_arst_vcyc", 64'(vc), 64'd4);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
